// File: rtl/pattern_counter_pkg.sv
// Shared types and helpers for the pattern counter: sequence modes and lap length.
package pattern_counter_pkg;

  typedef enum logic [1:0] {
    JERKY  = 2'd0,
    WALK   = 2'd1,
    BOUNCE = 2'd2,
    BINARY = 2'd3
  } mode_t;

  localparam mode_t MODE_RESET = JERKY;

  // Lap length in phases; longint so BINARY at width 32 (2^32) still fits.
  function automatic longint seq_len(input mode_t m, input int width);
    longint len;
    case (m)
      JERKY:   len = longint'(2 * (width - 1));
      WALK:    len = longint'(width);
      BOUNCE:  len = longint'(2 * (width - 1));
      default: len = longint'(1) << width;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/pattern_decode.sv
// Combinational phase-to-pattern decoder for each sequence mode.
module pattern_decode
  import pattern_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  mode_t            mode,
  input  logic [WIDTH-1:0] phase,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] W_VAL   = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] TWO_WM1 = WIDTH'(2 * (WIDTH - 1));

  always_comb begin
    value = ONE;
    case (mode)
      JERKY:   value = phase[0] ? (ONE << ((phase >> 1) + ONE)) : ONE;
      WALK:    value = ONE << phase;
      // Climb to the top bit, then fall back down without repeating the ends.
      BOUNCE:  value = (phase < W_VAL) ? (ONE << phase) : (ONE << (TWO_WM1 - phase));
      BINARY:  value = phase;
      default: value = ONE;
    endcase
  end

endmodule

// File: rtl/pattern_counter.sv
// Multi-mode pattern sequencer with registered count and lap pulse.
// Optional reverse stepping via macro PATTERN_COUNTER_REVERSE_EN (adds port dir).
// Handshake: none; en is a level enable sampled every rising edge, outputs are registered.
module pattern_counter
  import pattern_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  mode_t            mode,
`ifdef PATTERN_COUNTER_REVERSE_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  mode_t            mode_q;
  logic [WIDTH-1:0] phase;

  mode_t            mode_n;
  logic [WIDTH-1:0] phase_n;
  logic             wrap_n;
  logic [WIDTH-1:0] count_n;
  logic [WIDTH-1:0] last_phase;
  logic             rev;

`ifdef PATTERN_COUNTER_REVERSE_EN
  assign rev = dir;
`else
  assign rev = 1'b0;
`endif

  assign last_phase = WIDTH'(seq_len(mode_q, WIDTH) - longint'(1));

  // Priority: clear, then mode change, then enabled step.
  always_comb begin
    mode_n  = mode_q;
    phase_n = phase;
    wrap_n  = 1'b0;
    if (clear) begin
      mode_n  = mode;
      phase_n = '0;
    end else if (mode != mode_q) begin
      mode_n  = mode;
      phase_n = '0;
    end else if (en) begin
      if (rev) begin
        wrap_n  = (phase == '0);
        phase_n = wrap_n ? last_phase : (phase - WIDTH'(1));
      end else begin
        wrap_n  = (phase == last_phase);
        phase_n = wrap_n ? '0 : (phase + WIDTH'(1));
      end
    end
  end

  // Decode the next state so count lands on the same edge as phase.
  pattern_decode #(.WIDTH(WIDTH)) u_decode (
    .mode  (mode_n),
    .phase (phase_n),
    .value (count_n)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_q <= MODE_RESET;
      phase  <= '0;
      count  <= WIDTH'(1);
      wrap   <= 1'b0;
    end else begin
      mode_q <= mode_n;
      phase  <= phase_n;
      count  <= count_n;
      wrap   <= wrap_n;
    end
  end

endmodule

// File: tb/tb_pattern_counter.sv
// Self-checking bench for pattern_counter (WIDTH=8), scoreboard driven.
module tb_pattern_counter;
  import pattern_counter_pkg::*;

  localparam int W = 8;
`ifdef PATTERN_COUNTER_REVERSE_EN
  localparam bit HAS_DIR = 1'b1;
`else
  localparam bit HAS_DIR = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic         en;
  logic         clear;
  mode_t        mode;
  logic         dir;
  logic [W-1:0] count;
  logic         wrap;

  int checks   = 0;
  int failures = 0;

  logic [W:0] exp_q[$];
  mode_t      m_mode;
  int         m_phase;

  int jerky_tbl[14]  = '{2, 1, 4, 1, 8, 1, 16, 1, 32, 1, 64, 1, 128, 1};
  int bounce_tbl[14] = '{2, 4, 8, 16, 32, 64, 128, 64, 32, 16, 8, 4, 2, 1};
  int rev_tbl[5]     = '{128, 1, 64, 1, 32};

  pattern_counter #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .en    (en),
    .clear (clear),
    .mode  (mode),
`ifdef PATTERN_COUNTER_REVERSE_EN
    .dir   (dir),
`endif
    .count (count),
    .wrap  (wrap)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int m_len(input mode_t md);
    case (md)
      JERKY:   return 2 * (W - 1);
      WALK:    return W;
      BOUNCE:  return 2 * (W - 1);
      default: return 1 << W;
    endcase
  endfunction

  function automatic int ref_val(input mode_t md, input int p);
    case (md)
      JERKY:   return (p % 2 == 0) ? 1 : (1 << (p / 2 + 1));
      WALK:    return 1 << p;
      BOUNCE:  return (p < W) ? (1 << p) : (1 << (2 * (W - 1) - p));
      default: return p;
    endcase
  endfunction

  // driver: apply inputs, predict, wait one edge, then score
  task automatic cyc(input string tag, input logic e, input logic c, input mode_t md, input logic d);
    logic       w;
    logic [W:0] exp;
    en = e; clear = c; mode = md; dir = d;
    w = 1'b0;
    if (c) begin
      m_mode = md; m_phase = 0;
    end else if (md != m_mode) begin
      m_mode = md; m_phase = 0;
    end else if (e) begin
      if (d) begin
        w = (m_phase == 0);
        m_phase = w ? m_len(m_mode) - 1 : m_phase - 1;
      end else begin
        w = (m_phase == m_len(m_mode) - 1);
        m_phase = w ? 0 : m_phase + 1;
      end
    end
    exp_q.push_back({W'(ref_val(m_mode, m_phase)), w});
    @(posedge clock);
    #1;
    exp = exp_q.pop_front();
    check({tag, "_count"}, 32'(count), 32'(exp[W:1]));
    check({tag, "_wrap"}, 32'(wrap), 32'(exp[0]));
  endtask

  task automatic model_reset();
    m_mode = JERKY;
    m_phase = 0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; clear = 1'b0; mode = JERKY; dir = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset_count", 32'(count), 32'd1);
    check("reset_wrap", 32'(wrap), 32'd0);
    check("reset_mode", 32'(dut.mode_q), 32'(JERKY));
    reset = 1'b0;

    // JERKY lap
    for (int i = 0; i < 14; i++) begin
      cyc("jerky", 1'b1, 1'b0, JERKY, 1'b0);
      check("jerky_tbl", 32'(count), 32'(jerky_tbl[i]));
      check("jerky_tblwrap", 32'(wrap), (i == 13) ? 32'd1 : 32'd0);
    end

    // advance to phase 7, then clear into WALK
    for (int i = 0; i < 7; i++) cyc("jerky7", 1'b1, 1'b0, JERKY, 1'b0);
    check("jerky7_val", 32'(count), 32'd16);
    cyc("clear_walk", 1'b1, 1'b1, WALK, 1'b0);
    check("clear_walk_mode", 32'(dut.mode_q), 32'(WALK));
    cyc("walk_step", 1'b1, 1'b0, WALK, 1'b0);
    check("walk_step_val", 32'(count), 32'd2);

    // WALK to 32, then asynchronous reset between edges
    for (int i = 0; i < 4; i++) cyc("walk", 1'b1, 1'b0, WALK, 1'b0);
    check("walk32", 32'(count), 32'd32);
    #2 reset = 1'b1;
    #1;
    check("async_rst_count", 32'(count), 32'd1);
    check("async_rst_wrap", 32'(wrap), 32'd0);
    model_reset();
    @(posedge clock);
    #1 reset = 1'b0;
    cyc("rel_walk", 1'b1, 1'b0, WALK, 1'b0);
    check("rel_walk_mode", 32'(dut.mode_q), 32'(WALK));

    // BOUNCE lap
    cyc("bounce_chg", 1'b1, 1'b0, BOUNCE, 1'b0);
    check("bounce_chg_val", 32'(count), 32'd1);
    for (int i = 0; i < 14; i++) begin
      cyc("bounce", 1'b1, 1'b0, BOUNCE, 1'b0);
      check("bounce_tbl", 32'(count), 32'(bounce_tbl[i]));
      check("bounce_tblwrap", 32'(wrap), (i == 13) ? 32'd1 : 32'd0);
    end

    // BINARY full lap and hold
    cyc("binary_chg", 1'b0, 1'b0, BINARY, 1'b0);
    for (int i = 0; i < 256; i++) begin
      cyc("binary", 1'b1, 1'b0, BINARY, 1'b0);
      check("binary_val", 32'(count), 32'((i + 1) % 256));
    end
    for (int i = 0; i < 3; i++) begin
      cyc("hold", 1'b0, 1'b0, BINARY, 1'b0);
      check("hold_val", 32'(count), 32'd0);
    end

    // randomized mix of clears, mode changes, enables
    for (int i = 0; i < 300; i++) begin
      int    r;
      logic  c, e, d;
      mode_t md;
      r  = $urandom_range(0, 15);
      c  = (r == 0);
      md = (r == 1) ? mode_t'($urandom_range(0, 3)) : m_mode;
      e  = ($urandom_range(0, 3) != 0);
      d  = HAS_DIR ? 1'($urandom_range(0, 1)) : 1'b0;
      cyc("rand", e, c, md, d);
    end

    // reset clears a live wrap pulse
    cyc("wclr", 1'b0, 1'b1, WALK, 1'b0);
    for (int i = 0; i < 8; i++) cyc("wlap", 1'b1, 1'b0, WALK, 1'b0);
    check("wlap_wrap", 32'(wrap), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_wrap_drop", 32'(wrap), 32'd0);
    check("rst_wrap_count", 32'(count), 32'd1);
    model_reset();
    @(posedge clock);
    #1 reset = 1'b0;

`ifdef PATTERN_COUNTER_REVERSE_EN
    for (int i = 0; i < 5; i++) begin
      cyc("rev", 1'b1, 1'b0, JERKY, 1'b1);
      check("rev_tbl", 32'(count), 32'(rev_tbl[i]));
      check("rev_tblwrap", 32'(wrap), (i == 0) ? 32'd1 : 32'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
